dtpu_sequencer: RTL

Parametrised control sequencer for the DTPU, and successor to the fixed 8x8 control FSM inside `dtpu_core`. It fetches precision, FP mode and batch count from the CSR memory, then runs the requested number of weight tiles through the MXU. Each tile is one weight-memory fetch, one input-FIFO load, one compute window and one output-FIFO write. Compared with the previous generation, it adds input and output FIFO back-pressure stalls, a programmable batch count, precision validation with an error state, and weight-address wrap-around.

---
 rtl/dtpu_sequencer_if.sv | 50 +++++
 rtl/dtpu_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dtpu_sequencer_if.sv
// dtpu_sequencer_if
// Bundles every non-clock, non-reset signal of the DTPU control sequencer.
//   master : the sequencer side (drives status, CSR/weight-memory strobes,
//            FIFO strobes, MXU enable and the latched configuration)
//   slave  : the environment side (PS control, CSR read data, FIFO flags)
// Port summary:
//   enable, cs_start, cs_continue          PS control in
//   cs_idle, cs_ready, cs_done             status out
//   csr_address, csr_ce / csr_dout         CSR memory (1-cycle read latency)
//   wm_address, wm_ce                      weight memory
//   infifo_is_empty / infifo_read          input FIFO
//   outfifo_is_full / outfifo_write        output FIFO
//   mxu_en, precision, fp_mode, err, state datapath control and debug
interface dtpu_sequencer_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH_CSR = 8
);
  logic                      enable;
  logic                      cs_start;
  logic                      cs_continue;
  logic                      cs_idle;
  logic                      cs_ready;
  logic                      cs_done;
  logic [ADDR_WIDTH-1:0]     csr_address;
  logic                      csr_ce;
  logic [DATA_WIDTH_CSR-1:0] csr_dout;
  logic [ADDR_WIDTH-1:0]     wm_address;
  logic                      wm_ce;
  logic                      infifo_is_empty;
  logic                      infifo_read;
  logic                      outfifo_is_full;
  logic                      outfifo_write;
  logic                      mxu_en;
  logic [3:0]                precision;
  logic [3:0]                fp_mode;
  logic                      err;
  logic [3:0]                state;

  modport master (
    input  enable, cs_start, cs_continue, csr_dout, infifo_is_empty, outfifo_is_full,
    output cs_idle, cs_ready, cs_done, csr_address, csr_ce, wm_address, wm_ce,
           infifo_read, outfifo_write, mxu_en, precision, fp_mode, err, state
  );

  modport slave (
    output enable, cs_start, cs_continue, csr_dout, infifo_is_empty, outfifo_is_full,
    input  cs_idle, cs_ready, cs_done, csr_address, csr_ce, wm_address, wm_ce,
           infifo_read, outfifo_write, mxu_en, precision, fp_mode, err, state
  );
endinterface

// File: rtl/dtpu_sequencer.sv
// dtpu_sequencer
// Control sequencer for the DTPU. Reads precision, FP mode and batch count
// from the CSR memory, then runs batch tiles through the MXU: one weight-row
// fetch, ROWS input-FIFO reads inside a COMPUTE_LAT-cycle compute window,
// and one output-FIFO write per tile. Stalls on an empty input FIFO and on a
// full output FIFO; an unsupported precision parks the FSM in ERROR.
// Ports:
//   clk      rising-edge clock
//   aresetn  synchronous active-low reset
//   bus      dtpu_sequencer_if.master (control, CSR, weight memory, FIFOs,
//            MXU enable, configuration and state outputs)
module dtpu_sequencer #(
  parameter int ROWS           = 8,
  parameter int COLUMNS        = 8,
  parameter int COMPUTE_LAT    = 3*(ROWS+1) + 2*COLUMNS + 1,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH_CSR = 8,
  parameter int A_PRECISION    = 0,
  parameter int A_FP_MODE      = 1,
  parameter int A_BATCH        = 2,
  parameter int WM_BASE        = 0,
  parameter int WM_DEPTH       = 2048
) (
  input logic              clk,
  input logic              aresetn,
  dtpu_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(COMPUTE_LAT + 1);
  localparam int ROW_W = (WM_DEPTH > 1) ? $clog2(WM_DEPTH) : 1;

  typedef enum logic [3:0] {
    ST_POWER_UP = 4'h0, ST_IDLE     = 4'h1, ST_COMPUTE  = 4'h2, ST_DONE     = 4'h3,
    ST_RETRIEVE = 4'h4, ST_SAVE     = 4'h5, ST_START_P1 = 4'h6, ST_START_P2 = 4'h7,
    ST_START_P3 = 4'h8, ST_START_P4 = 4'h9, ST_WAIT_IN  = 4'hA, ST_ERROR    = 4'hC
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                precision_q, precision_d;
  logic [3:0]                fp_mode_q, fp_mode_d;
  logic [DATA_WIDTH_CSR-1:0] batch_q, batch_d;
  logic [DATA_WIDTH_CSR-1:0] tile_q, tile_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic                      prec_ok;
  logic                      load_phase;
  logic                      cnt_advance;
  logic [DATA_WIDTH_CSR:0]   tile_inc;
  logic                      more_tiles;
  logic [ROW_W-1:0]          row_inc;
  logic [ADDR_WIDTH-1:0]     csr_addr;

  assign prec_ok    = (precision_q == 4'd1) || (precision_q == 4'd2) ||
                      (precision_q == 4'd4) || (precision_q == 4'd8);
  // During the first ROWS counts every count consumes one input word, so the
  // counter value doubles as the number of words loaded so far.
  assign load_phase  = cnt_q < CNT_W'(ROWS);
  assign cnt_advance = !load_phase || !bus.infifo_is_empty;
  // One extra bit so batch = 2^DATA_WIDTH_CSR - 1 terminates cleanly.
  assign tile_inc    = {1'b0, tile_q} + 1'b1;
  assign more_tiles  = tile_inc < {1'b0, batch_q};
  assign row_inc     = (row_q == ROW_W'(WM_DEPTH - 1)) ? '0 : row_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    precision_d = precision_q;
    fp_mode_d   = fp_mode_q;
    batch_d     = batch_q;
    tile_d      = tile_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    if (bus.enable) begin
      unique case (state_q)
        ST_POWER_UP: state_d = ST_IDLE;
        ST_IDLE:     if (bus.cs_start) state_d = ST_START_P1;
        ST_START_P1: state_d = ST_START_P2;
        ST_START_P2: begin
          precision_d = bus.csr_dout[3:0];
          state_d     = ST_START_P3;
        end
        ST_START_P3: begin
          fp_mode_d = bus.csr_dout[3:0];
          state_d   = ST_START_P4;
        end
        ST_START_P4: begin
          batch_d = (bus.csr_dout == '0) ? DATA_WIDTH_CSR'(1) : bus.csr_dout;
          if (prec_ok) begin
            tile_d  = '0;
            row_d   = '0;
            cnt_d   = '0;
            state_d = ST_RETRIEVE;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_ERROR:    if (!bus.cs_start) state_d = ST_IDLE;
        ST_RETRIEVE: begin
          cnt_d   = '0;
          state_d = bus.infifo_is_empty ? ST_WAIT_IN : ST_COMPUTE;
        end
        ST_WAIT_IN:  if (!bus.infifo_is_empty) state_d = ST_COMPUTE;
        ST_COMPUTE: begin
          if (cnt_advance) begin
            if (cnt_q == CNT_W'(COMPUTE_LAT - 1)) begin
              cnt_d   = '0;
              state_d = ST_SAVE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_SAVE:     if (!bus.outfifo_is_full) state_d = ST_DONE;
        ST_DONE: begin
          tile_d  = tile_inc[DATA_WIDTH_CSR-1:0];
          row_d   = row_inc;
          state_d = (more_tiles || bus.cs_continue) ? ST_RETRIEVE : ST_IDLE;
        end
        default:     state_d = ST_POWER_UP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= ST_POWER_UP;
      precision_q <= '0;
      fp_mode_q   <= '0;
      batch_q     <= '0;
      tile_q      <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      precision_q <= precision_d;
      fp_mode_q   <= fp_mode_d;
      batch_q     <= batch_d;
      tile_q      <= tile_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    csr_addr = '0;
    case (state_q)
      ST_START_P1: csr_addr = ADDR_WIDTH'(A_PRECISION);
      ST_START_P2: csr_addr = ADDR_WIDTH'(A_FP_MODE);
      ST_START_P3: csr_addr = ADDR_WIDTH'(A_BATCH);
      default:     csr_addr = '0;
    endcase
  end

  // Strobes are decoded from the registered state and gated by enable, so a
  // frozen FSM never issues memory or FIFO traffic. Pulse-type status is
  // gated too, so a freeze in START_P4 or DONE cannot stretch the pulse.
  assign bus.state         = state_q;
  assign bus.precision     = precision_q;
  assign bus.fp_mode       = fp_mode_q;
  assign bus.err           = (state_q == ST_ERROR);
  assign bus.cs_idle       = (state_q == ST_IDLE);
  assign bus.cs_ready      = bus.enable && (state_q == ST_START_P4) && prec_ok;
  assign bus.cs_done       = bus.enable && (state_q == ST_DONE) && !more_tiles && !bus.cs_continue;
  assign bus.csr_address   = csr_addr;
  assign bus.csr_ce        = bus.enable && ((state_q == ST_START_P1) || (state_q == ST_START_P2) ||
                                            (state_q == ST_START_P3));
  assign bus.wm_ce         = bus.enable && (state_q == ST_RETRIEVE);
  assign bus.wm_address    = (state_q == ST_RETRIEVE) ? ADDR_WIDTH'(WM_BASE) + ADDR_WIDTH'(row_q) : '0;
  assign bus.infifo_read   = bus.enable && (state_q == ST_COMPUTE) && load_phase && !bus.infifo_is_empty;
  assign bus.mxu_en        = bus.enable && (state_q == ST_COMPUTE) && cnt_advance;
  assign bus.outfifo_write = bus.enable && (state_q == ST_SAVE) && !bus.outfifo_is_full;

endmodule
